// File: rtl/qp_fetch_scheduler.sv
// rtl/qp_fetch_scheduler.sv - round-robin send-queue WQE fetch scheduler with per-QP outstanding caps
//
// Purpose:
//    Picks which active QP receives the next WQE fetch grant. Scanning starts at a rotating
//    pointer. New grants are blocked while the WQE cache is almost full. Each QP may have at
//    most MAX_OUTSTANDING fetches granted but not yet written to the cache.
//
// Configuration macro:
//    QP_WEIGHT_EN - when defined, the pointer stays on a winner for up to i_qp_weight[winner]
//                   consecutive grants (a weight of 0 counts as 1). When undefined, each QP
//                   gets one grant per turn and i_qp_weight is ignored.
//
// Ports:
//    clk                 in   clock
//    rst_n               in   asynchronous active-low reset
//    i_active            in   per-QP "send queue has work" level
//    i_wqe_cache_alfull  in   WQE cache almost full; blocks new grants
//    i_wqe_fetch_ready   in   fetch engine can accept a grant
//    i_fetch_done_val    in   one WQE has been written to the cache (credit return)
//    i_fetch_done_qpn    in   QP that the returned credit belongs to
//    i_qp_weight         in   per-QP burst weight; QP n occupies bits [4n+3:4n]
//    o_arbit_val         out  one-cycle grant pulse
//    o_qp_idx            out  granted QP index; holds the last grant between pulses
//    o_qp_idx_one_hot    out  one-hot form of o_qp_idx
//    o_credit_err        out  sticky flag: credit returned to a QP with zero outstanding fetches
module qp_fetch_scheduler #(
   parameter int MAX_QP          = 32,
   parameter int QP_PTR_WIDTH    = 5,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [MAX_QP-1:0]         i_active,
   input  logic                      i_wqe_cache_alfull,
   input  logic                      i_wqe_fetch_ready,
   input  logic                      i_fetch_done_val,
   input  logic [QP_PTR_WIDTH-1:0]   i_fetch_done_qpn,
   input  logic [MAX_QP*4-1:0]       i_qp_weight,
   output logic                      o_arbit_val,
   output logic [QP_PTR_WIDTH-1:0]   o_qp_idx,
   output logic [MAX_QP-1:0]         o_qp_idx_one_hot,
   output logic                      o_credit_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD} state_t;

   state_t                    r_state;
   logic                      r_arbit_val;
   logic [QP_PTR_WIDTH-1:0]   r_qp_idx;
   logic [MAX_QP-1:0]         r_qp_idx_one_hot;
   logic                      r_credit_err;
   logic [QP_PTR_WIDTH-1:0]   r_ptr;
   logic [CNT_WIDTH-1:0]      r_outstanding [MAX_QP];

   logic [MAX_QP-1:0]         w_eligible;
   logic [MAX_QP-1:0]         w_nonzero;
   logic                      w_found;
   logic [QP_PTR_WIDTH-1:0]   w_winner;
   logic [MAX_QP-1:0]         w_winner_oh;
   logic [QP_PTR_WIDTH-1:0]   w_ptr_inc;
   logic                      w_grant;
   logic [MAX_QP-1:0]         w_inc;
   logic [MAX_QP-1:0]         w_credit_oh;
   logic [MAX_QP-1:0]         w_dec;
   logic                      w_credit_err;
   logic                      w_stay;

   assign o_arbit_val      = r_arbit_val;
   assign o_qp_idx         = r_qp_idx;
   assign o_qp_idx_one_hot = r_qp_idx_one_hot;
   assign o_credit_err     = r_credit_err;

   always_comb begin
      for (int n = 0; n < MAX_QP; n++) begin
         w_nonzero[n]  = (r_outstanding[n] != '0);
         w_eligible[n] = i_active[n] && (r_outstanding[n] < CNT_WIDTH'(MAX_OUTSTANDING));
      end
   end

   // First eligible QP at or after the pointer, wrapping past MAX_QP-1 back to 0.
   always_comb begin
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int i = 0; i < MAX_QP; i++) begin
         v_idx = int'(r_ptr) + i;
         if (v_idx >= MAX_QP) v_idx = v_idx - MAX_QP;
         if (!w_found && w_eligible[v_idx[QP_PTR_WIDTH-1:0]]) begin
            w_found  = 1'b1;
            w_winner = v_idx[QP_PTR_WIDTH-1:0];
         end
      end
   end

   assign w_winner_oh = MAX_QP'(1) << w_winner;
   assign w_ptr_inc   = (w_winner == QP_PTR_WIDTH'(MAX_QP - 1)) ? '0 : w_winner + 1'b1;
   assign w_grant     = (r_state == ST_IDLE) && i_wqe_fetch_ready && !i_wqe_cache_alfull && w_found;

   // Credits aimed at an empty counter are dropped and flagged instead of underflowing.
   assign w_inc        = w_grant ? w_winner_oh : '0;
   assign w_credit_oh  = i_fetch_done_val ? (MAX_QP'(1) << i_fetch_done_qpn) : '0;
   assign w_dec        = w_credit_oh & w_nonzero;
   assign w_credit_err = |(w_credit_oh & ~w_nonzero);

`ifdef QP_WEIGHT_EN
   logic [3:0] r_burst;
   logic [3:0] w_weight;
   logic [3:0] w_burst_next;

   // A burst only continues while the winner is the QP the pointer rests on; if the scan
   // had to skip past it, the pointed-at QP went ineligible and the new winner starts fresh.
   always_comb begin
      w_weight = i_qp_weight[{w_winner, 2'b00} +: 4];
      if (w_weight == 4'd0) w_weight = 4'd1;
      w_burst_next = ((w_winner == r_ptr) ? r_burst : 4'd0) + 4'd1;
      w_stay       = (w_burst_next < w_weight);
   end
`else
   logic w_unused_weight;
   assign w_unused_weight = ^i_qp_weight;
   assign w_stay          = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_arbit_val      <= 1'b0;
         r_qp_idx         <= '0;
         r_qp_idx_one_hot <= '0;
         r_ptr            <= '0;
`ifdef QP_WEIGHT_EN
         r_burst          <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_arbit_val      <= 1'b1;
                  r_qp_idx         <= w_winner;
                  r_qp_idx_one_hot <= w_winner_oh;
                  r_ptr            <= w_stay ? w_winner : w_ptr_inc;
`ifdef QP_WEIGHT_EN
                  r_burst          <= w_stay ? w_burst_next : 4'd0;
`endif
                  r_state          <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_arbit_val <= 1'b0;
               r_state     <= ST_HOLD;
            end
            // One dead cycle so a late ready de-assert from the fetch engine is not missed.
            ST_HOLD: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_arbit_val <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < MAX_QP; n++) r_outstanding[n] <= '0;
         r_credit_err <= 1'b0;
      end else begin
         for (int n = 0; n < MAX_QP; n++) begin
            if (w_inc[n] && !w_dec[n])
               r_outstanding[n] <= r_outstanding[n] + 1'b1;
            else if (w_dec[n] && !w_inc[n])
               r_outstanding[n] <= r_outstanding[n] - 1'b1;
         end
         if (w_credit_err) r_credit_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_qp_fetch_scheduler.sv
// tb/tb_qp_fetch_scheduler.sv - directed self-checking bench for qp_fetch_scheduler
module tb_qp_fetch_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  i_active;
   logic         i_wqe_cache_alfull;
   logic         i_wqe_fetch_ready;
   logic         i_fetch_done_val;
   logic [4:0]   i_fetch_done_qpn;
   logic [127:0] i_qp_weight;
   logic         o_arbit_val;
   logic [4:0]   o_qp_idx;
   logic [31:0]  o_qp_idx_one_hot;
   logic         o_credit_err;

   int n_tests = 0;
   int n_fail  = 0;

   qp_fetch_scheduler dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_active           (i_active),
      .i_wqe_cache_alfull (i_wqe_cache_alfull),
      .i_wqe_fetch_ready  (i_wqe_fetch_ready),
      .i_fetch_done_val   (i_fetch_done_val),
      .i_fetch_done_qpn   (i_fetch_done_qpn),
      .i_qp_weight        (i_qp_weight),
      .o_arbit_val        (o_arbit_val),
      .o_qp_idx           (o_qp_idx),
      .o_qp_idx_one_hot   (o_qp_idx_one_hot),
      .o_credit_err       (o_credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n              = 1'b0;
      i_active           = '0;
      i_wqe_cache_alfull = 1'b0;
      i_wqe_fetch_ready  = 1'b0;
      i_fetch_done_val   = 1'b0;
      i_fetch_done_qpn   = '0;
      i_qp_weight        = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits for the next grant pulse; optionally returns its credit during the following cycle.
   task automatic next_grant(input bit credit, output logic [4:0] idx);
      bit got;
      got = 1'b0;
      idx = '0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         i_fetch_done_val = 1'b0;
         if (o_arbit_val) begin
            got = 1'b1;
            idx = o_qp_idx;
            if (credit) begin
               i_fetch_done_val = 1'b1;
               i_fetch_done_qpn = o_qp_idx;
            end
         end
      end
      chk("grant_within_budget", 32'(got), 32'd1);
   endtask

   task automatic count_grants(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         i_fetch_done_val = 1'b0;
         if (o_arbit_val) n++;
      end
   endtask

   initial begin
      logic [4:0]  g;
      logic [31:0] oh;
      int          n;
      int          rr_order [6];
      rr_order = '{1, 5, 31, 1, 5, 31};

      rst_n              = 1'b0;
      i_active           = '0;
      i_wqe_cache_alfull = 1'b0;
      i_wqe_fetch_ready  = 1'b0;
      i_fetch_done_val   = 1'b0;
      i_fetch_done_qpn   = '0;
      i_qp_weight        = '0;
      repeat (2) @(negedge clk);
      chk("rst_arbit_val", 32'(o_arbit_val), 32'd0);
      chk("rst_qp_idx", 32'(o_qp_idx), 32'd0);
      chk("rst_one_hot", o_qp_idx_one_hot, 32'd0);
      chk("rst_credit_err", 32'(o_credit_err), 32'd0);
      rst_n = 1'b1;

      // Only QP3 active, no credits: grants at cycles 1,4,7,10 then stops at the cap of 4.
      i_active          = 32'h0000_0008;
      i_wqe_fetch_ready = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         chk($sformatf("qp3_val_c%0d", c), 32'(o_arbit_val),
             32'((c == 1) || (c == 4) || (c == 7) || (c == 10)));
         chk($sformatf("qp3_idx_c%0d", c), 32'(o_qp_idx), 32'd3);
         chk($sformatf("qp3_oh_c%0d", c), o_qp_idx_one_hot, 32'h0000_0008);
      end

      // QP1, QP5, QP31 active with credits returned: order wraps 31 -> 1.
      do_reset();
      i_active          = 32'h8000_0022;
      i_wqe_fetch_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         next_grant(1'b1, g);
         chk($sformatf("rr_order_%0d", k), 32'(g), 32'(rr_order[k]));
         oh = 32'd1 << rr_order[k];
         chk($sformatf("rr_one_hot_%0d", k), o_qp_idx_one_hot, oh);
      end
      chk("rr_no_credit_err", 32'(o_credit_err), 32'd0);

      // Almost-full blocks QP0; grant appears one cycle after it falls.
      do_reset();
      i_active           = 32'h0000_0001;
      i_wqe_fetch_ready  = 1'b1;
      i_wqe_cache_alfull = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("alfull_block_c%0d", c), 32'(o_arbit_val), 32'd0);
      end
      i_wqe_cache_alfull = 1'b0;
      @(negedge clk);
      chk("alfull_release_val", 32'(o_arbit_val), 32'd1);
      chk("alfull_release_idx", 32'(o_qp_idx), 32'd0);
      chk("alfull_release_oh", o_qp_idx_one_hot, 32'd1);

      // QP2 saturates at 4 outstanding; one credit reopens it in the next IDLE window.
      do_reset();
      i_active          = 32'h0000_0004;
      i_wqe_fetch_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next_grant(1'b0, g);
         chk($sformatf("qp2_fill_%0d", k), 32'(g), 32'd2);
      end
      count_grants(6, n);
      chk("qp2_capped", 32'(n), 32'd0);
      i_fetch_done_val = 1'b1;
      i_fetch_done_qpn = 5'd2;
      @(negedge clk);
      i_fetch_done_val = 1'b0;
      chk("qp2_credit_wait", 32'(o_arbit_val), 32'd0);
      @(negedge clk);
      chk("qp2_regrant_val", 32'(o_arbit_val), 32'd1);
      chk("qp2_regrant_idx", 32'(o_qp_idx), 32'd2);

      // QP7 at 2 outstanding: grant and credit in the same edge leave it at 2, so
      // exactly 3 grants follow (this one plus two more up to the cap).
      do_reset();
      i_active          = 32'h0000_0080;
      i_wqe_fetch_ready = 1'b1;
      next_grant(1'b0, g);
      chk("qp7_first", 32'(g), 32'd7);
      next_grant(1'b0, g);
      chk("qp7_second", 32'(g), 32'd7);
      @(negedge clk);
      @(negedge clk);
      i_fetch_done_val = 1'b1;
      i_fetch_done_qpn = 5'd7;
      count_grants(20, n);
      chk("qp7_net_zero_grants", 32'(n), 32'd3);
      chk("qp7_no_credit_err", 32'(o_credit_err), 32'd0);
      i_fetch_done_val = 1'b1;
      i_fetch_done_qpn = 5'd9;
      @(negedge clk);
      i_fetch_done_val = 1'b0;
      chk("qp9_credit_err_set", 32'(o_credit_err), 32'd1);
      repeat (3) @(negedge clk);
      chk("qp9_credit_err_sticky", 32'(o_credit_err), 32'd1);

      // Reset during GRANT: outputs clear at once and QP4's counter restarts from zero.
      do_reset();
      i_active          = 32'h0000_0010;
      i_wqe_fetch_ready = 1'b1;
      next_grant(1'b0, g);
      chk("qp4_pre_reset_idx", 32'(g), 32'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_val", 32'(o_arbit_val), 32'd0);
      chk("mid_rst_idx", 32'(o_qp_idx), 32'd0);
      chk("mid_rst_oh", o_qp_idx_one_hot, 32'd0);
      chk("mid_rst_err_cleared", 32'(o_credit_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_grants(20, n);
      chk("qp4_post_reset_grants", 32'(n), 32'd4);

`ifdef QP_WEIGHT_EN
      begin
         int wt_order [8];
         wt_order = '{0, 0, 0, 1, 0, 0, 0, 1};
         do_reset();
         i_qp_weight       = 128'h13;
         i_active          = 32'h0000_0003;
         i_wqe_fetch_ready = 1'b1;
         for (int k = 0; k < 8; k++) begin
            next_grant(1'b1, g);
            chk($sformatf("weight_order_%0d", k), 32'(g), 32'(wt_order[k]));
         end
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
